// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the Wishbone memory/IO bus controller.
// Holds the FSM state encoding, bus widths and the split-access address helper.
package mem_bus_ctrl_pkg;

    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 16;
    localparam int WB_ADR_W = 19;
    localparam int SEL_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CYC1 = 2'd1,
        ST_CYC2 = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Word address of (a + 1) with 20-bit wrap, so byte FFFFFh rolls over to word 00000h.
    function automatic logic [WB_ADR_W-1:0] next_word_adr(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:1] + {{(WB_ADR_W-1){1'b0}}, a[0]};
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_lane_mux.sv
// Combinational byte-lane steering: byte selects and write-data placement for each bus
// cycle, plus extraction/assembly of the read word from the returned lanes.
module mem_bus_ctrl_lane_mux
    import mem_bus_ctrl_pkg::*;
(
    input  logic              odd_i,
    input  logic              byteop_i,
    input  logic              second_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [7:0]        first_byte_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [DATA_W-1:0] rd_word_o
);

    always_comb begin
        sel_o = 2'b11;
        dat_o = wr_data_i;
        if (second_i) begin
            // Second half of a split word: high byte goes to the low lane of the next word.
            sel_o = 2'b01;
            dat_o = {8'h00, wr_data_i[15:8]};
        end else if (odd_i) begin
            sel_o = 2'b10;
            dat_o = {wr_data_i[7:0], 8'h00};
        end else if (byteop_i) begin
            sel_o = 2'b01;
            dat_o = {8'h00, wr_data_i[7:0]};
        end
    end

    always_comb begin
        rd_word_o = rd_data_i;
        if (byteop_i) begin
            rd_word_o = {8'h00, (odd_i ? rd_data_i[15:8] : rd_data_i[7:0])};
        end else if (odd_i) begin
            rd_word_o = {rd_data_i[7:0], first_byte_i};
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Turns per-microinstruction memory/IO requests into Wishbone-classic cycles on a 16-bit bus,
// splitting odd-address word accesses into two byte cycles and pulsing mem_rdy on completion.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 0,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_req,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                we,
    input  logic                m_io,
    input  logic                byteop,
    output logic [DATA_W-1:0]   memout,
    output logic                mem_rdy,
    output logic                bus_err,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [SEL_W-1:0]    wb_sel_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                wb_we_o,
    output logic                wb_tga_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                state_q,  state_d;
    logic [ADDR_W-1:0]     addr_q,   addr_d;
    logic [DATA_W-1:0]     wdata_q,  wdata_d;
    logic                  byteop_q, byteop_d;
    logic                  we_q,     we_d;
    logic                  tga_q,    tga_d;
    logic [WB_ADR_W-1:0]   adr_q,    adr_d;
    logic [SEL_W-1:0]      sel_q,    sel_d;
    logic [DATA_W-1:0]     dat_q,    dat_d;
    logic                  cyc_q,    cyc_d;
    logic                  stb_q,    stb_d;
    logic [DATA_W-1:0]     memout_q, memout_d;
    logic [7:0]            lo_q,     lo_d;
    logic                  err_q,    err_d;
    logic [TIMEOUT_W-1:0]  cnt_q,    cnt_d;

    logic                  idle;
    logic                  mux_odd;
    logic                  mux_byte;
    logic [DATA_W-1:0]     mux_wdata;
    logic [SEL_W-1:0]      mux_sel;
    logic [DATA_W-1:0]     mux_dat;
    logic [DATA_W-1:0]     rd_word;
    logic                  live_ack;
    logic                  timed_out;

    // While idle the lanes are steered from the incoming request, afterwards from the latched one.
    assign idle      = (state_q == ST_IDLE);
    assign mux_odd   = idle ? addr[0] : addr_q[0];
    assign mux_byte  = idle ? byteop  : byteop_q;
    assign mux_wdata = idle ? wr_data : wdata_q;

    mem_bus_ctrl_lane_mux u_lane_mux (
        .odd_i        (mux_odd),
        .byteop_i     (mux_byte),
        .second_i     (!idle),
        .wr_data_i    (mux_wdata),
        .rd_data_i    (wb_dat_i),
        .first_byte_i (lo_q),
        .sel_o        (mux_sel),
        .dat_o        (mux_dat),
        .rd_word_o    (rd_word)
    );

    assign live_ack  = stb_q && wb_ack_i;
    assign timed_out = (TIMEOUT != 0) && stb_q && !wb_ack_i && (cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        byteop_d = byteop_q;
        we_d     = we_q;
        tga_d    = tga_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        memout_d = memout_q;
        lo_d     = lo_q;
        err_d    = 1'b0;
        cnt_d    = (stb_q && !wb_ack_i) ? cnt_q + TIMEOUT_W'(1) : cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    addr_d   = addr;
                    wdata_d  = wr_data;
                    byteop_d = byteop;
                    we_d     = we;
                    tga_d    = m_io;
                    adr_d    = addr[ADDR_W-1:1];
                    sel_d    = mux_sel;
                    dat_d    = mux_dat;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_CYC1;
                end
            end
            ST_CYC1: begin
                if (timed_out) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    memout_d = 16'hFFFF;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else if (live_ack) begin
                    if (!byteop_q && addr_q[0]) begin
                        // Keep cyc asserted; stb rests one cycle before the second byte cycle.
                        lo_d    = wb_dat_i[15:8];
                        adr_d   = next_word_adr(addr_q);
                        sel_d   = mux_sel;
                        dat_d   = mux_dat;
                        stb_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_CYC2;
                    end else begin
                        if (!we_q) begin
                            memout_d = rd_word;
                        end
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CYC2: begin
                if (!stb_q) begin
                    stb_d = 1'b1;
                end else if (timed_out) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    memout_d = 16'hFFFF;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else if (live_ack) begin
                    if (!we_q) begin
                        memout_d = rd_word;
                    end
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteop_q <= 1'b0;
            we_q     <= 1'b0;
            tga_q    <= 1'b0;
            adr_q    <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            memout_q <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            byteop_q <= byteop_d;
            we_q     <= we_d;
            tga_q    <= tga_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            memout_q <= memout_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign memout   = memout_q;
    assign mem_rdy  = (state_q == ST_DONE);
    assign bus_err  = err_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_tga_o = tga_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;

endmodule
